// File: rtl/contador_dezena_min_horas_if.sv
// Bundles the carry input, preset/load controls and the displayed digits of the
// tens-of-minutes / hours stage of the digital clock.
interface contador_dezena_min_horas_if;
   logic       carry_um;
   logic       load;
   logic [3:0] presetDm;
   logic [3:0] presetUh;
   logic [3:0] presetDh;
   logic [3:0] qDezenadeMinutos;
   logic [3:0] qUnidadedeHoras;
   logic [3:0] qDezenadeHoras;
   logic       load_err;
   logic       dia_pulse;

   modport master (
      output carry_um, load, presetDm, presetUh, presetDh,
      input  qDezenadeMinutos, qUnidadedeHoras, qDezenadeHoras, load_err, dia_pulse
   );

   modport slave (
      input  carry_um, load, presetDm, presetUh, presetDh,
      output qDezenadeMinutos, qUnidadedeHoras, qDezenadeHoras, load_err, dia_pulse
   );
endinterface

// File: rtl/contador_dezena_min_horas.sv
// Tens-of-minutes and BCD hours stage: advances on each falling edge of the
// minutes-units carry, supports validated preset loads and flags day rollover.
module contador_dezena_min_horas #(
   parameter int HORA_MAX_DEZ = 2,
   parameter int HORA_MAX_UN  = 3,
   parameter int DM_MAX       = 5
) (
   input  logic                          clk,
   input  logic                          clear,
   contador_dezena_min_horas_if.slave    bus
);

   localparam logic [3:0] DH_WRAP = 4'(HORA_MAX_DEZ);
   localparam logic [3:0] UH_WRAP = 4'(HORA_MAX_UN);
   localparam logic [3:0] DM_TOP  = 4'(DM_MAX);

   logic       carry_q, carry_d;
   logic [3:0] dm_q, dm_d;
   logic [3:0] uh_q, uh_d;
   logic [3:0] dh_q, dh_d;
   logic       load_err_q, load_err_d;
   logic       dia_pulse_q, dia_pulse_d;

   logic tick;
   logic load_valid;

   // A tick is the sampled 1->0 transition of carry, i.e. minutes-units 9 -> 0.
   assign tick = carry_q & ~bus.carry_um;

   assign load_valid = (bus.presetDm <= DM_TOP)
                     && (bus.presetDh <= DH_WRAP)
                     && (bus.presetUh <= 4'd9)
                     && ((bus.presetDh < DH_WRAP) || (bus.presetUh <= UH_WRAP));

   always_comb begin
      carry_d     = bus.carry_um;
      dm_d        = dm_q;
      uh_d        = uh_q;
      dh_d        = dh_q;
      load_err_d  = 1'b0;
      dia_pulse_d = 1'b0;

      // A load request, accepted or rejected, swallows any tick in the same cycle.
      if (bus.load) begin
         if (load_valid) begin
            dm_d = bus.presetDm;
            uh_d = bus.presetUh;
            dh_d = bus.presetDh;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (tick) begin
         if (dm_q < DM_TOP) begin
            dm_d = dm_q + 4'd1;
         end else begin
            dm_d = 4'd0;
            if ((dh_q == DH_WRAP) && (uh_q == UH_WRAP)) begin
               dh_d        = 4'd0;
               uh_d        = 4'd0;
               dia_pulse_d = 1'b1;
            end else if (uh_q == 4'd9) begin
               uh_d = 4'd0;
               dh_d = dh_q + 4'd1;
            end else begin
               uh_d = uh_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         carry_q     <= 1'b0;
         dm_q        <= 4'd0;
         uh_q        <= 4'd0;
         dh_q        <= 4'd0;
         load_err_q  <= 1'b0;
         dia_pulse_q <= 1'b0;
      end else begin
         carry_q     <= carry_d;
         dm_q        <= dm_d;
         uh_q        <= uh_d;
         dh_q        <= dh_d;
         load_err_q  <= load_err_d;
         dia_pulse_q <= dia_pulse_d;
      end
   end

   assign bus.qDezenadeMinutos = dm_q;
   assign bus.qUnidadedeHoras  = uh_q;
   assign bus.qDezenadeHoras   = dh_q;
   assign bus.load_err         = load_err_q;
   assign bus.dia_pulse        = dia_pulse_q;

endmodule

// File: tb/tb_contador_dezena_min_horas.sv
// Directed bench for the tens-of-minutes / hours stage; each step drives inputs
// just after a rising edge and checks registered outputs one edge later.
module tb_contador_dezena_min_horas;
   logic clk;
   logic clear;
   int   checks;
   int   errors;

   contador_dezena_min_horas_if bus ();

   contador_dezena_min_horas dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic carry, input logic ld,
                                input logic [3:0] dm, input logic [3:0] uh,
                                input logic [3:0] dh);
      bus.carry_um = carry;
      bus.load     = ld;
      bus.presetDm = dm;
      bus.presetUh = uh;
      bus.presetDh = dh;
   endtask

   // Compares the three digits plus both pulses as one vector against expectation.
   task automatic checkOutput(input string tag, input logic [3:0] dm,
                              input logic [3:0] uh, input logic [3:0] dh,
                              input logic lerr, input logic dpulse);
      logic [13:0] observed;
      logic [13:0] expected;
      observed = {bus.qDezenadeHoras, bus.qUnidadedeHoras, bus.qDezenadeMinutos,
                  bus.load_err, bus.dia_pulse};
      expected = {dh, uh, dm, lerr, dpulse};
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed Dh=%0d Uh=%0d Dm=%0d err=%b dia=%b, expected Dh=%0d Uh=%0d Dm=%0d err=%b dia=%b",
                tag, observed[13:10], observed[9:6], observed[5:2], observed[1], observed[0],
                dh, uh, dm, lerr, dpulse);
      end
   endtask

   task automatic carryPulse();
      bus.carry_um = 1'b1;
      step(1);
      bus.carry_um = 1'b0;
      step(1);
   endtask

   task automatic doLoad(input logic [3:0] dm, input logic [3:0] uh, input logic [3:0] dh);
      applyStimulus(1'b0, 1'b1, dm, uh, dh);
      step(1);
      bus.load = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear  = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

      step(2);
      checkOutput("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      clear = 1'b0;
      step(10);
      checkOutput("idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

      // Rising edge ignored, falling edge advances one cycle later.
      bus.carry_um = 1'b1;
      step(3);
      checkOutput("rise_ignored", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      bus.carry_um = 1'b0;
      checkOutput("before_tick_edge", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      step(1);
      checkOutput("first_tick", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
      step(3);
      checkOutput("single_tick_only", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);

      repeat (4) carryPulse();
      checkOutput("dm_five", 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
      carryPulse();
      checkOutput("dm_wrap_uh1", 4'd0, 4'd1, 4'd0, 1'b0, 1'b0);

      doLoad(4'd5, 4'd9, 4'd0);
      checkOutput("load_09_5", 4'd5, 4'd9, 4'd0, 1'b0, 1'b0);
      carryPulse();
      checkOutput("hour_carry", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);

      doLoad(4'd5, 4'd3, 4'd2);
      checkOutput("load_23_5", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);
      carryPulse();
      checkOutput("day_rollover", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
      step(1);
      checkOutput("dia_one_cycle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

      doLoad(4'd0, 4'd4, 4'd2);
      checkOutput("bad_24", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
      step(1);
      checkOutput("err_one_cycle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      doLoad(4'd6, 4'd0, 4'd0);
      checkOutput("bad_dm6", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
      doLoad(4'd0, 4'd0, 4'd3);
      checkOutput("bad_dh3", 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
      doLoad(4'd4, 4'd9, 4'd1);
      checkOutput("good_19_4", 4'd4, 4'd9, 4'd1, 1'b0, 1'b0);

      // Load arriving in the same cycle as a tick wins and the tick is dropped.
      bus.carry_um = 1'b1;
      step(1);
      applyStimulus(1'b0, 1'b1, 4'd5, 4'd3, 4'd2);
      step(1);
      checkOutput("load_tick_collide", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);
      bus.load = 1'b0;
      step(1);
      checkOutput("no_late_tick", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);

      bus.carry_um = 1'b1;
      step(1);
      bus.carry_um = 1'b0;
      clear        = 1'b1;
      step(1);
      checkOutput("clear_tick_collide", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

      // Carry high through release of clear: only the later fall counts.
      bus.carry_um = 1'b1;
      step(1);
      clear = 1'b0;
      step(5);
      checkOutput("carry_held_high", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      bus.carry_um = 1'b0;
      step(1);
      checkOutput("fall_after_clear", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
      step(2);
      checkOutput("exactly_one_tick", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/contador_dezena_min_horas.md
Name: contador_dezena_min_horas

Overview:
- Stage directly downstream of the minutes-units counter in the digital-clock chain.
- Consumes that counter's carry level `carry_um`, which is high while minutes-units = 9.
- Maintains the tens-of-minutes digit (0-5) and the BCD hours (00-23).
- Supports time-setting loads and produces a one-cycle day-rollover pulse.

Parameters:
- HORA_MAX_DEZ, 2, tens-of-hours value at which hour wrap is checked.
- HORA_MAX_UN, 3, units-of-hours value that, with HORA_MAX_DEZ, triggers the wrap to 00.
- DM_MAX, 5, maximum tens-of-minutes value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous active-high reset.
- carry_um  input  1  level from minutes-units stage, high while units = 9.
- load  input  1  one-cycle request to load the preset digits.
- presetDm  input  4  BCD tens-of-minutes to load.
- presetUh  input  4  BCD hours-units to load.
- presetDh  input  4  BCD hours-tens to load.
- qDezenadeMinutos  output  4  tens-of-minutes digit (0-5).
- qUnidadedeHoras  output  4  hours-units digit (0-9; 0-3 when tens = 2).
- qDezenadeHoras  output  4  hours-tens digit (0-2).
- load_err  output  1  one-cycle pulse: load rejected as invalid.
- dia_pulse  output  1  one-cycle pulse on 23:5x -> 00:0x rollover.

Behaviour:
- Reset (clear = 1 at a rising edge):
  - All digits go to 0 and `carry_q` goes to 0.
  - `load_err` and `dia_pulse` go to 0.
  - Reset overrides load and tick in the same cycle.
- Edge detect:
  - Register `carry_q <= carry_um` every cycle.
  - Define `tick = carry_q & ~carry_um`, i.e. the falling edge, marking minutes-units 9 -> 0.
  - The rising edge is ignored.
  - Latency: digits update on the clock edge after the cycle in which the falling edge is sampled. That is, 1 cycle after carry_um drops.
- Tick advance:
  - If Dm < DM_MAX: Dm + 1.
  - Otherwise Dm <- 0 and the hour advances:
    - If Dh = HORA_MAX_DEZ and Uh = HORA_MAX_UN: Dh <- 0, Uh <- 0, and `dia_pulse` = 1 for that cycle.
    - Else if Uh = 9: Uh <- 0, Dh + 1.
    - Else: Uh + 1.
- Load:
  - Valid when presetDm <= 5, presetDh <= 2, presetUh <= 9, and (presetDh < 2 or presetUh <= 3).
  - When valid, all three digits are loaded on the next edge.
  - When invalid, digits are unchanged and `load_err` = 1 for one cycle.
- Simultaneous load and tick:
  - Load has priority and the tick is discarded. No increment is applied to the loaded value.
  - `dia_pulse` stays 0.
  - `carry_q` still updates normally, so no spurious tick occurs next cycle.
- Pulses: `load_err` and `dia_pulse` are registered and high for exactly one cycle, 0 otherwise.
- carry_um held high indefinitely: no tick, digits hold.
- carry_um high at release of clear: `carry_q` = 0, so no tick is generated (only falling edges count). A later fall produces exactly one tick.
- Glitch policy: each sampled 1->0 transition is one tick. Upstream guarantees the level is synchronous to clk.
- Invariant: outputs never show an illegal time. Dm stays in 0-5 and hours in 00-23 under every sequence.

Test Plan:
- Reset then idle:
  - Stimulus: clear = 1 for 2 cycles, carry_um = 0 for 10 cycles.
  - Required: all digits 0, both pulses 0.
- Basic increment:
  - Stimulus: from 00:0x, carry_um high 3 cycles then low.
  - Required: Dm = 1 exactly 1 cycle after the fall, no change on the rise.
  - Then 5 more pulses: Dm 5 -> 0 with Uh = 1.
- Hour carry:
  - Stimulus: load Dh = 0, Uh = 9, Dm = 5, then one carry pulse.
  - Required: 10:0x, i.e. Dh = 1, Uh = 0, Dm = 0, dia_pulse = 0.
- Day rollover:
  - Stimulus: load 2/3/5, then one carry pulse.
  - Required: 00:0x and dia_pulse = 1 for exactly one cycle.
- Invalid loads:
  - Stimulus: load Dh = 2, Uh = 4, Dm = 0; then load Dm = 6; then load Dh = 3.
  - Required: each gives load_err = 1 for one cycle, digits unchanged.
  - Then load 1/9/4: accepted, load_err = 0.
- Collisions:
  - Stimulus: load 2/3/5 in the tick cycle.
  - Required: 23:5x shown, dia_pulse = 0, no tick next cycle.
  - Stimulus: clear asserted in a tick cycle.
  - Required: all 0, no pulse.
